wb_cmd_master: RTL and testbench

- Byte-stream-driven Wishbone initiator that issues single read/write cycles onto the I/O bus, i.e. the slave port of the I/O controller.
- Command bytes arrive from a UART receive path; response bytes go back to a UART transmit path.
- Lets a host debugger peek/poke any I/O register (LEDs, segreg, fan, timers, SPI, ...) without CPU involvement.
- Classic Wishbone: one outstanding cycle, no pipelining, no burst.

---
 rtl/wb_cmd_master_if.sv | 50 +++++
 rtl/wb_cmd_master.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
//   Bundles the three handshake groups of the byte-stream Wishbone initiator:
//     rx_*  : command bytes in  (valid/ready)
//     tx_*  : response bytes out (valid/ready)
//     Wishbone single-cycle initiator signals (cyc/stb/we/adr/dat/sel/ack)
//   modport master : the command master itself
//   modport slave  : everything around it (UART rx/tx paths + I/O bus slave)
//
//   Handshake rule for rx and tx: a byte moves on a rising clock edge where
//   valid and ready are both high. Once valid is raised, the sender holds
//   valid and data stable until that edge. Ready may be raised or dropped
//   freely and never depends on valid.
// ---------------------------------------------------------------------------
interface wb_cmd_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [16:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Turns command bytes from a UART receive path into single Wishbone
//   read/write cycles on the I/O bus and returns a status byte (plus four
//   read-data bytes for a successful read) to a UART transmit path.
//
//   Frame (big-endian fields):
//     opcode [7:4]=1 read / 2 write, [3:0]=byte selects
//     3 address bytes (low 17 bits used)
//     4 data bytes (write only)
//   Status: 0x00 ok, 0xE1 no ack within TIMEOUT bus cycles, 0xEE bad opcode.
//
// Ports
//   clk_i       : system clock, rising edge
//   rst_i       : asynchronous active-low reset
//   bus         : rx/tx byte streams and Wishbone initiator (master modport)
//   busy        : high whenever a command is in progress
//   o_dbg_state : current FSM state, for debug/observation
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_cmd_master_if.master        bus,
    output logic                   busy,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        S_OPC = 3'd0,
        S_ADR = 3'd1,
        S_DAT = 3'd2,
        S_BUS = 3'd3,
        S_STS = 3'd4,
        S_RD  = 3'd5
    } state_t;

    // Counter is at least 10 bits and grows if TIMEOUT needs more.
    localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    localparam logic [7:0] STS_OK  = 8'h00;
    localparam logic [7:0] STS_TMO = 8'hE1;
    localparam logic [7:0] STS_BAD = 8'hEE;

    state_t         r_state;
    state_t         w_next;

    logic           r_we;
    logic [3:0]     r_sel;
    logic [16:0]    r_adr;
    logic [31:0]    r_dat;
    logic [31:0]    r_rdat;
    logic [7:0]     r_sts;
    logic [1:0]     r_cnt;
    logic [TW-1:0]  r_tmo;

    logic           w_rx_acc;
    logic           w_tx_acc;
    logic           w_opc_ok;
    logic           w_opc_wr;
    logic           w_tmo_hit;

    assign w_rx_acc  = bus.rx_valid & bus.rx_ready;
    assign w_tx_acc  = bus.tx_valid & bus.tx_ready;
    assign w_opc_wr  = (bus.rx_data[7:4] == 4'h2);
    assign w_opc_ok  = (bus.rx_data[7:4] == 4'h1) | w_opc_wr;
    // r_tmo counts completed S_BUS cycles, so the TIMEOUT-th bus cycle is
    // the last one; cyc_o is therefore high for exactly TIMEOUT cycles.
    assign w_tmo_hit = (r_tmo >= TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_OPC;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OPC: begin
                if (w_rx_acc) begin
                    w_next = w_opc_ok ? S_ADR : S_STS;
                end
            end
            S_ADR: begin
                if (w_rx_acc && (r_cnt == 2'd2)) begin
                    w_next = r_we ? S_DAT : S_BUS;
                end
            end
            S_DAT: begin
                if (w_rx_acc && (r_cnt == 2'd3)) begin
                    w_next = S_BUS;
                end
            end
            S_BUS: begin
                // ack and timeout in the same cycle both leave; the datapath
                // gives ack priority for the status value.
                if (bus.ack_i || w_tmo_hit) begin
                    w_next = S_STS;
                end
            end
            S_STS: begin
                if (w_tx_acc) begin
                    w_next = ((r_sts == STS_OK) && !r_we) ? S_RD : S_OPC;
                end
            end
            S_RD: begin
                if (w_tx_acc && (r_cnt == 2'd3)) begin
                    w_next = S_OPC;
                end
            end
            default: w_next = S_OPC;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we   <= 1'b0;
            r_sel  <= 4'h0;
            r_adr  <= 17'h0;
            r_dat  <= 32'h0;
            r_rdat <= 32'h0;
            r_sts  <= 8'h00;
            r_cnt  <= 2'd0;
            r_tmo  <= '0;
        end else begin
            case (r_state)
                S_OPC: begin
                    if (w_rx_acc) begin
                        r_cnt <= 2'd0;
                        if (w_opc_ok) begin
                            r_we  <= w_opc_wr;
                            r_sel <= bus.rx_data[3:0];
                        end else begin
                            r_sts <= STS_BAD;
                        end
                    end
                end
                S_ADR: begin
                    if (w_rx_acc) begin
                        // Older address bits fall off the top, leaving the
                        // low 17 bits of the 24-bit field.
                        r_adr <= {r_adr[8:0], bus.rx_data};
                        r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
                    end
                end
                S_DAT: begin
                    if (w_rx_acc) begin
                        r_dat <= {r_dat[23:0], bus.rx_data};
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    if (bus.ack_i) begin
                        r_sts <= STS_OK;
                        if (!r_we) begin
                            r_rdat <= bus.dat_i;
                        end
                    end else if (w_tmo_hit) begin
                        r_sts <= STS_TMO;
                    end
                end
                S_STS: begin
                    if (w_tx_acc) begin
                        r_cnt <= 2'd0;
                    end
                end
                S_RD: begin
                    if (w_tx_acc) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase

            // Cleared outside S_BUS so every bus cycle starts from zero;
            // saturates rather than wrapping.
            if (r_state != S_BUS) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.rx_ready = (r_state == S_OPC) || (r_state == S_ADR) || (r_state == S_DAT);
        bus.tx_valid = (r_state == S_STS) || (r_state == S_RD);
        bus.tx_data  = r_sts;
        if (r_state == S_RD) begin
            case (r_cnt)
                2'd0:    bus.tx_data = r_rdat[31:24];
                2'd1:    bus.tx_data = r_rdat[23:16];
                2'd2:    bus.tx_data = r_rdat[15:8];
                default: bus.tx_data = r_rdat[7:0];
            endcase
        end
        // cyc/stb follow the state directly so an async reset drops them
        // at once.
        bus.cyc_o   = (r_state == S_BUS);
        bus.stb_o   = (r_state == S_BUS);
        bus.we_o    = r_we;
        bus.adr_o   = r_adr;
        bus.dat_o   = r_dat;
        bus.sel_o   = r_sel;
        busy        = (r_state != S_OPC);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int TMO   = 16;
    localparam int LIMIT = 3000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       busy;
    logic [2:0] dbg_state;

    always #5 clk_i = ~clk_i;

    wb_cmd_master_if bus();

    wb_cmd_master #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Check / scoreboard state
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;
        int          ack_at;
    } bus_t;

    logic [7:0]  exp_q[$];
    bus_t        exp_bus_q[$];
    logic [31:0] slave_mem [int];
    logic [31:0] model_mem [int];

    int tx_pushed    = 0;
    int tx_seen      = 0;
    int tx_hold_at   = -1;
    int tx_hold_left = 0;

    // Contents of a never-written I/O register, shared by slave and model.
    function automatic logic [31:0] mem_default(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        tx_pushed++;
    endtask

    // ------------------------------------------------------------------
    // Wishbone slave: acks on the configured bus cycle, checks every
    // cycle against the expected transaction, random ack noise when idle.
    // ------------------------------------------------------------------
    int cyc_cnt = 0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            cyc_cnt    = 0;
            bus.ack_i  = 1'b0;
            bus.dat_i  = 32'h0;
        end else if (bus.cyc_o) begin
            cyc_cnt++;
            if (exp_bus_q.size() == 0) begin
                if (cyc_cnt == 1) check("bus_unexpected_cyc", 64'(1), 64'(0));
                bus.ack_i = 1'b0;
            end else begin
                check("bus_stb", 64'(bus.stb_o), 64'(1));
                check("bus_we",  64'(bus.we_o),  64'(exp_bus_q[0].we));
                check("bus_adr", 64'(bus.adr_o), 64'(exp_bus_q[0].adr));
                check("bus_sel", 64'(bus.sel_o), 64'(exp_bus_q[0].sel));
                if (exp_bus_q[0].we) check("bus_dat", 64'(bus.dat_o), 64'(exp_bus_q[0].dat));
                if (exp_bus_q[0].ack_at == cyc_cnt) begin
                    bus.ack_i = 1'b1;
                    if (bus.we_o) begin
                        slave_mem[int'(bus.adr_o)] = bus.dat_o;
                        bus.dat_i = $urandom;
                    end else begin
                        bus.dat_i = slave_mem.exists(int'(bus.adr_o)) ?
                                    slave_mem[int'(bus.adr_o)] : mem_default(int'(bus.adr_o));
                    end
                end else begin
                    bus.ack_i = 1'b0;
                    bus.dat_i = $urandom;
                end
            end
        end else begin
            if (cyc_cnt > 0 && exp_bus_q.size() > 0) begin
                check("bus_len", 64'(cyc_cnt), 64'(exp_bus_q[0].len));
                void'(exp_bus_q.pop_front());
            end
            cyc_cnt   = 0;
            bus.ack_i = ($urandom_range(0, 3) == 0);
            bus.dat_i = $urandom;
        end
    end

    // ------------------------------------------------------------------
    // Tx sink: random ready, optional forced stall, compares each byte
    // against the expected queue and checks bytes are held while stalled.
    // ------------------------------------------------------------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_stall   = 1'b0;
            bus.tx_ready = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_valid_held", 64'(bus.tx_valid), 64'(1));
                check("tx_data_held",  64'(bus.tx_data),  64'(prev_data));
            end
            if (bus.tx_valid && tx_seen == tx_hold_at && tx_hold_left > 0) begin
                bus.tx_ready = 1'b0;
                tx_hold_left--;
            end else begin
                bus.tx_ready = ($urandom_range(0, 3) != 0);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) check("tx_extra_byte", 64'(bus.tx_data), 64'h100);
                else                   check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
                tx_seen++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = bus.tx_valid;
                prev_data  = bus.tx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit first);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= LIMIT) check("rx_accept_timeout", 64'(n), 64'(0));
        else if (first) check("opc_taken_idle", 64'(busy), 64'(0));
        @(negedge clk_i);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || exp_bus_q.size() != 0 || busy) && n < LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        check("cmd_complete", 64'(n < LIMIT), 64'(1));
    endtask

    // Reference model: derives the expected bus cycle and response bytes
    // from the command, then drives the frame.
    task automatic do_cmd(input logic [7:0] opc, input logic [23:0] adr, input logic [31:0] wd,
                          input int ack_at, input bit wait_done, input bit stall_rd);
        bus_t        t;
        logic [31:0] rv;
        int          a;
        bit          ok_opc;
        bit          we;
        bit          timed_out;
        ok_opc = (opc[7:4] == 4'h1) || (opc[7:4] == 4'h2);
        we     = (opc[7:4] == 4'h2);
        a      = int'(adr[16:0]);
        if (!ok_opc) begin
            push_exp(8'hEE);
        end else begin
            timed_out = (ack_at < 1) || (ack_at > TMO);
            t.we     = we;
            t.adr    = adr[16:0];
            t.dat    = wd;
            t.sel    = opc[3:0];
            t.ack_at = ack_at;
            t.len    = timed_out ? TMO : ack_at;
            exp_bus_q.push_back(t);
            if (timed_out) begin
                push_exp(8'hE1);
            end else if (we) begin
                push_exp(8'h00);
                model_mem[a] = wd;
            end else begin
                rv = model_mem.exists(a) ? model_mem[a] : mem_default(a);
                if (stall_rd) begin
                    tx_hold_at   = tx_pushed + 2;
                    tx_hold_left = 5;
                end
                push_exp(8'h00);
                for (int i = 3; i >= 0; i--) push_exp(rv[8*i +: 8]);
            end
        end
        send_byte(opc, 1'b1);
        if (ok_opc) begin
            for (int i = 2; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b0);
            if (we) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8], 1'b0);
        end
        if (wait_done) wait_idle();
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_cyc"},      64'(bus.cyc_o),    64'(0));
        check({pfx, "_stb"},      64'(bus.stb_o),    64'(0));
        check({pfx, "_tx_valid"}, 64'(bus.tx_valid), 64'(0));
        check({pfx, "_busy"},     64'(busy),         64'(0));
        check({pfx, "_rx_ready"}, 64'(bus.rx_ready), 64'(1));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_i        = 1'b0;
        repeat (3) @(negedge clk_i);

        check_idle_outputs("reset");
        check("reset_we",      64'(bus.we_o),    64'(0));
        check("reset_adr",     64'(bus.adr_o),   64'(0));
        check("reset_dat",     64'(bus.dat_o),   64'(0));
        check("reset_sel",     64'(bus.sel_o),   64'(0));
        check("reset_tx_data", 64'(bus.tx_data), 64'(0));

        rst_i = 1'b1;
        @(negedge clk_i);

        slave_mem[32'h01000] = 32'h0000A5C3;
        model_mem[32'h01000] = 32'h0000A5C3;

        // Read, ack on 3rd bus cycle, 5-cycle stall in the data bytes.
        do_cmd(8'h1F, 24'h001000, 32'h0, 3, 1'b1, 1'b1);
        // Write 0x155 to the LED register, then read it back.
        do_cmd(8'h2F, 24'h001000, 32'h00000155, 2, 1'b1, 1'b0);
        check("led_reg", 64'(slave_mem[32'h01000]), 64'h155);
        do_cmd(8'h1F, 24'h001000, 32'h0, 1, 1'b1, 1'b0);
        // Timeout, then a normal command.
        do_cmd(8'h13, 24'h0ABCDE, 32'h0, 0, 1'b1, 1'b0);
        do_cmd(8'h13, 24'h0ABCDE, 32'h0, 5, 1'b1, 1'b0);
        // Ack on the very last allowed cycle wins; one cycle later is a timeout.
        do_cmd(8'h2A, 24'hFF0123, 32'hDEADBEEF, TMO, 1'b1, 1'b0);
        do_cmd(8'h25, 24'h000777, 32'h12345678, TMO + 1, 1'b1, 1'b0);
        // Bad opcode, then a read with sel 0.
        do_cmd(8'h37, 24'h0, 32'h0, 0, 1'b1, 1'b0);
        do_cmd(8'h10, 24'h001000, 32'h0, 2, 1'b1, 1'b0);
        // Next opcode presented while the previous command is on the bus.
        do_cmd(8'h1C, 24'h012345, 32'h0, 4, 1'b0, 1'b0);
        do_cmd(8'h2F, 24'h0FFFFF, 32'hCAFEF00D, 2, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int          r;
            int          r2;
            int          ack;
            logic [7:0]  opc;
            r = $urandom_range(0, 9);
            if (r < 4)      opc = {4'h1, 4'($urandom)};
            else if (r < 8) opc = {4'h2, 4'($urandom)};
            else begin
                opc = 8'($urandom);
                while (opc[7:4] == 4'h1 || opc[7:4] == 4'h2) opc = 8'($urandom);
            end
            r2 = $urandom_range(0, 9);
            if (r2 == 0)      ack = 0;
            else if (r2 == 1) ack = TMO + 1;
            else if (r2 == 2) ack = TMO;
            else              ack = $urandom_range(1, 6);
            do_cmd(opc, 24'($urandom), $urandom, ack,
                   (k == 39) || ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a write cycle.
        do_cmd(8'h2F, 24'h001000, 32'h0BAD0BAD, 0, 1'b0, 1'b0);
        n = 0;
        while (!bus.cyc_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("rst_test_cyc_seen", 64'(bus.cyc_o), 64'(1));
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk_i);
        exp_q.delete();
        exp_bus_q.delete();
        tx_pushed    = tx_seen;
        tx_hold_left = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("rst_release");
        check("rst_release_adr", 64'(bus.adr_o), 64'(0));

        // Aborted write must not have reached the register.
        do_cmd(8'h1F, 24'h001000, 32'h0, 3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
